regfile_np: RTL and testbench



---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_np_mux_n1.sv | 55 +++++
 rtl/regfile_np.sv | 107 ++++++++++
 tb/tb_regfile_np.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// The zero register always sits at the top index of the array.
package regfile_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 32;

  typedef logic [DEF_WIDTH-1:0] word_t;

  function automatic int zero_idx(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/regfile_np_mux_n1.sv
// Generic N:1 tree mux built recursively from 2:1 stages, one level per select bit.
// A select value beyond N-1 returns zero, so a missing subtree simply becomes a constant.
module mux_n1 #(
  parameter int WIDTH = 64,
  parameter int N     = 32,
  parameter int SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][WIDTH-1:0] data_i,
  input  logic [SW-1:0]           sel_i,
  output logic [WIDTH-1:0]        data_o
);

  if (SW == 1) begin : g_leaf
    if (N == 1) begin : g_one
      assign data_o = sel_i[0] ? '0 : data_i[0];
    end else begin : g_two
      assign data_o = sel_i[0] ? data_i[1] : data_i[0];
    end
  end else begin : g_node
    // The low half covers select values with the top bit clear.
    localparam int HALF = 1 << (SW - 1);
    localparam int NL   = (N < HALF) ? N : HALF;
    localparam int NU   = N - NL;

    logic [WIDTH-1:0] lo_data;
    logic [WIDTH-1:0] hi_data;

    mux_n1 #(
      .WIDTH(WIDTH),
      .N    (NL),
      .SW   (SW - 1)
    ) u_lo (
      .data_i(data_i[NL-1:0]),
      .sel_i (sel_i[SW-2:0]),
      .data_o(lo_data)
    );

    if (NU > 0) begin : g_hi
      mux_n1 #(
        .WIDTH(WIDTH),
        .N    (NU),
        .SW   (SW - 1)
      ) u_hi (
        .data_i(data_i[N-1:NL]),
        .sel_i (sel_i[SW-2:0]),
        .data_o(hi_data)
      );
    end else begin : g_no_hi
      assign hi_data = '0;
    end

    assign data_o = sel_i[SW-1] ? hi_data : lo_data;
  end

endmodule

// File: rtl/regfile_np.sv
// Multi-port register file: one write port, NREAD tree-mux read ports,
// optional hard-wired zero register, write-to-read bypass and registered outputs.
module regfile_np
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit REG_OUT  = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [NREAD-1:0][AW-1:0]    rd_addr,
  output logic [NREAD-1:0][WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]            rd_valid
);

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (int'(a) == zero_idx(DEPTH));
  endfunction

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_d;
  logic [NREAD-1:0][WIDTH-1:0] mux_out;
  logic [NREAD-1:0][WIDTH-1:0] rd_data_d;
  logic                        wr_ok;

  // A write that is dropped must also never be bypassed.
  always_comb begin
    wr_ok = wr_en && in_range(wr_addr) && !is_zero(wr_addr);
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (int'(wr_addr) == i)) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    mux_n1 #(
      .WIDTH(WIDTH),
      .N    (DEPTH)
    ) u_mux (
      .data_i(mem_q),
      .sel_i (rd_addr[p]),
      .data_o(mux_out[p])
    );
  end

  // Zero forcing is applied last so it outranks the bypass.
  always_comb begin
    rd_data_d = mux_out;
    for (int p = 0; p < NREAD; p++) begin
      if (BYPASS && wr_ok && (rd_addr[p] == wr_addr)) begin
        rd_data_d[p] = wr_data;
      end
      if (!in_range(rd_addr[p]) || is_zero(rd_addr[p])) begin
        rd_data_d[p] = '0;
      end
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic [NREAD-1:0][WIDTH-1:0] rd_data_q;
    logic [NREAD-1:0]            rd_valid_q;
    logic [NREAD-1:0]            rd_valid_d;

    always_comb begin
      rd_valid_d = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= '0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_comb_out
    assign rd_data  = rd_data_d;
    assign rd_valid = '1;
  end

endmodule

// File: tb/tb_regfile_np.sv
// Self-checking bench: four register-file configurations share one stimulus stream
// and are checked every cycle against an array model plus directed literal expectations.
module tb_regfile_np;

  logic                 clk     = 1'b0;
  logic                 rst_n   = 1'b1;
  logic                 wr_en   = 1'b0;
  logic [4:0]           wr_addr = '0;
  logic [63:0]          wr_data = '0;
  logic [1:0][4:0]      rd_addr = '0;

  logic [1:0][63:0]     rd_data_a, rd_data_b, rd_data_c, rd_data_d;
  logic [1:0]           rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [63:0] mem   [4][32];
  logic [63:0] exp_q [4][2];
  bit          vld_q [4];

  always #5 clk = ~clk;

  // a: bypass, comb out; b: no bypass; c: bypass, registered out; d: DEPTH=20
  regfile_np #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_OUT(1'b0))
    u_a (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
         .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));
  regfile_np #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b0), .REG_OUT(1'b0))
    u_b (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
         .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));
  regfile_np #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_OUT(1'b1))
    u_c (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
         .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c));
  regfile_np #(.WIDTH(64), .DEPTH(20), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_OUT(1'b0))
    u_d (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
         .rd_addr(rd_addr), .rd_data(rd_data_d), .rd_valid(rd_valid_d));

  function automatic int depth_of(input int k);
    return (k == 3) ? 20 : 32;
  endfunction

  function automatic bit bypass_of(input int k);
    return k != 1;
  endfunction

  function automatic bit regout_of(input int k);
    return k == 2;
  endfunction

  // Read value from the rules: out-of-range or zero register, then bypass, then storage.
  function automatic logic [63:0] model_read(input int k, input int p);
    int a;
    int d;
    a = int'(rd_addr[p]);
    d = depth_of(k);
    if (a >= d || a == d - 1) return '0;
    if (bypass_of(k) && wr_en && wr_addr == rd_addr[p]) return wr_data;
    return mem[k][a];
  endfunction

  function automatic logic [63:0] actual_data(input int k, input int p);
    case (k)
      0:       return rd_data_a[p];
      1:       return rd_data_b[p];
      2:       return rd_data_c[p];
      default: return rd_data_d[p];
    endcase
  endfunction

  function automatic logic actual_valid(input int k, input int p);
    case (k)
      0:       return rd_valid_a[p];
      1:       return rd_valid_b[p];
      2:       return rd_valid_c[p];
      default: return rd_valid_d[p];
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) mem[k][i] = '0;
      exp_q[k][0] = '0;
      exp_q[k][1] = '0;
      vld_q[k] = 1'b0;
    end
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial model_clear();

  // Registered-output expectations are captured from pre-edge state before storage updates.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int k = 0; k < 4; k++) begin
        for (int p = 0; p < 2; p++) exp_q[k][p] = model_read(k, p);
        vld_q[k] = 1'b1;
        if (wr_en && int'(wr_addr) < depth_of(k) - 1) mem[k][wr_addr] = wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 4; k++) begin
        for (int p = 0; p < 2; p++) begin
          check_output($sformatf("cmp dut%0d rd_data[%0d] addr %0d", k, p, rd_addr[p]),
                       actual_data(k, p),
                       regout_of(k) ? exp_q[k][p] : model_read(k, p));
          check_output($sformatf("cmp dut%0d rd_valid[%0d]", k, p),
                       64'(actual_valid(k, p)),
                       regout_of(k) ? 64'(vld_q[k]) : 64'd1);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                                input logic [4:0] r0, input logic [4:0] r1);
    @(posedge clk);
    #1;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    rd_addr[0] = r0;
    rd_addr[1] = r1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2;
    rst_n    = 1'b0;
    check_en = 1'b1;
    #1;
    check_output("reset c rd_valid", 64'(rd_valid_c), 64'd0);
    check_output("reset c rd_data0", rd_data_c[0], 64'd0);
    check_output("reset a rd_data0", rd_data_a[0], 64'd0);
    check_output("reset a rd_valid", 64'(rd_valid_a), 64'd3);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_output("c valid before first edge", 64'(rd_valid_c), 64'd0);

    apply_stimulus(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd6);
    check_output("c valid after first edge", 64'(rd_valid_c), 64'd3);
    check_output("a bypass reg5", rd_data_a[0], 64'hDEAD_BEEF);
    check_output("b no bypass reg5", rd_data_b[0], 64'd0);

    apply_stimulus(1'b0, 5'd0, 64'd0, 5'd5, 5'd6);
    check_output("a read reg5", rd_data_a[0], 64'hDEAD_BEEF);
    check_output("a read reg6", rd_data_a[1], 64'd0);
    check_output("b read reg5", rd_data_b[0], 64'hDEAD_BEEF);
    check_output("c bypass captured", rd_data_c[0], 64'hDEAD_BEEF);

    apply_stimulus(1'b1, 5'd31, 64'h1234, 5'd31, 5'd31);
    check_output("a zero reg bypass", rd_data_a[0], 64'd0);
    apply_stimulus(1'b0, 5'd0, 64'd0, 5'd31, 5'd31);
    check_output("a zero reg p0", rd_data_a[0], 64'd0);
    check_output("a zero reg p1", rd_data_a[1], 64'd0);

    apply_stimulus(1'b1, 5'd7, 64'hAA, 5'd7, 5'd7);
    check_output("a bypass reg7", rd_data_a[0], 64'hAA);
    check_output("b old reg7", rd_data_b[0], 64'd0);

    apply_stimulus(1'b1, 5'd3, 64'h33, 5'd0, 5'd0);
    apply_stimulus(1'b1, 5'd4, 64'h44, 5'd0, 5'd0);
    apply_stimulus(1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
    apply_stimulus(1'b0, 5'd0, 64'd0, 5'd4, 5'd4);
    check_output("c addr3 one edge later", rd_data_c[0], 64'h33);
    check_output("a addr4 comb", rd_data_a[0], 64'h44);
    apply_stimulus(1'b0, 5'd0, 64'd0, 5'd4, 5'd4);
    check_output("c addr4 one edge later", rd_data_c[0], 64'h44);

    for (int i = 0; i < 31; i++) apply_stimulus(1'b1, 5'(i), 64'(i + 1), 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      apply_stimulus(1'b0, 5'd0, 64'd0, 5'(a), 5'(31 - a));
      check_output($sformatf("sweep a addr %0d", a), rd_data_a[0], (a == 31) ? 64'd0 : 64'(a + 1));
      check_output($sformatf("sweep d addr %0d", a), rd_data_d[0], (a >= 19) ? 64'd0 : 64'(a + 1));
    end

    apply_stimulus(1'b0, 5'd0, 64'd0, 5'd5, 5'd6);
    check_output("a reg5 before reset", rd_data_a[0], 64'd6);
    rst_n = 1'b0;
    #1;
    check_output("midreset a rd0", rd_data_a[0], 64'd0);
    check_output("midreset a rd1", rd_data_a[1], 64'd0);
    check_output("midreset c rd0", rd_data_c[0], 64'd0);
    check_output("midreset c rd1", rd_data_c[1], 64'd0);
    check_output("midreset c valid", 64'(rd_valid_c), 64'd0);
    check_output("midreset d rd0", rd_data_d[0], 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 5'd0, 64'd0, 5'd5, 5'd6);
    check_output("after reset a reg5", rd_data_a[0], 64'd0);
    check_output("after reset c reg5", rd_data_c[0], 64'd0);
    check_output("after reset c valid", 64'(rd_valid_c), 64'd3);
    apply_stimulus(1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    check_output("after reset b reg1", rd_data_b[0], 64'd0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
